// File: rtl/uart_rx_buffer_if.sv
// CPU-facing bundle of the UART receive buffer: the serial pin, the read and
// clear strobes, and the show-ahead data/status port.
interface uart_rx_buffer_if;
    logic       rx_serial;
    logic       RE;
    logic       err_clr;
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic       overrun;
    logic       frame_err;

    // CPU / pin side drives the strobes and the line and observes the status.
    modport master (
        output rx_serial, RE, err_clr,
        input  data, empty, full, overrun, frame_err
    );

    // Receive buffer side.
    modport slave (
        input  rx_serial, RE, err_clr,
        output data, empty, full, overrun, frame_err
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver feeding a show-ahead FIFO drained by CPU read strobes.
// Sticky overrun / framing error flags are held until err_clr.
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              areset,
    uart_rx_buffer_if.slave   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic             sync1_q, sync2_q;
    logic             rxs_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_s;
    logic             ferr_set_s;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic             wr_en_s, pop_s, ovr_set_s;
    logic [7:0]       data_q, data_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    // Two-flop synchroniser for the asynchronous serial pin; idles high.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx_serial;
            sync2_q <= sync1_q;
        end
    end

    assign rxs_s = sync2_q;

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Frame decode: centre on the start bit, then sample each bit one period apart.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    if (!rxs_s) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_ZERO;
                        idx_d   = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {rxs_s, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    // Leave mid stop bit so an early next start bit is not missed.
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    if (rxs_s) begin
                        push_s = 1'b1;
                    end else begin
                        ferr_set_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = 3'd0;
            end
        endcase
    end

    // FIFO pointer/flag next state and the registered show-ahead head byte.
    always_comb begin
        pop_s     = bus.RE & ~empty_q;
        // A full FIFO still accepts the byte when the CPU pops in the same cycle.
        wr_en_s   = push_s & (~full_q | bus.RE);
        ovr_set_s = push_s & full_q & ~bus.RE;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        empty_d = (rd_ptr_d == wr_ptr_d);
        full_d  = (rd_ptr_d[AW] != wr_ptr_d[AW]) &&
                  (rd_ptr_d[AW-1:0] == wr_ptr_d[AW-1:0]);

        if (empty_d) begin
            data_d = 8'h00;
        end else if (wr_en_s && (rd_ptr_d == wr_ptr_q)) begin
            // New head is the byte being written this cycle; bypass storage.
            data_d = shift_q;
        end else begin
            data_d = mem_q[rd_ptr_d[AW-1:0]];
        end

        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (bus.err_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (ferr_set_s) begin
            frame_err_d = 1'b1;
        end else if (bus.err_clr) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    // Pointers, registered read port and sticky status flags.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            data_q      <= 8'h00;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_q      <= data_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: frames are bit-banged on the pin,
// expected bytes go into a scoreboard queue and are compared on each read.
module tb_uart_rx_buffer;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;
    // Stop sample falls CPB/2 + 9*CPB cycles after rxs goes low, which is two
    // cycles after the pin falls at offset 0 of the frame.
    localparam int STOP_OFS = 2 + CPB / 2 + 9 * CPB;

    logic clk;
    logic areset;
    int   errors;
    int   checks;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    uart_rx_buffer_if bus ();

    uart_rx_buffer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_re();
        bus.RE = 1'b1;
        @(posedge clk);
        #1;
        bus.RE = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
    endtask

    // Drive one frame starting right now (just after a rising edge).
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                              input bit re_at_stop, input bit clr_at_stop,
                              input bit chk_lat);
        logic [2:0] bi;
        logic [7:0] head;
        for (int c = 0; c < FRAME; c++) begin
            if (c < CPB) begin
                bus.rx_serial = 1'b0;
            end else if (c < 9 * CPB) begin
                bi = 3'((c - CPB) / CPB);
                bus.rx_serial = b[bi];
            end else begin
                bus.rx_serial = stop_lvl;
            end
            bus.RE      = re_at_stop  && (c == STOP_OFS);
            bus.err_clr = clr_at_stop && (c == STOP_OFS);
            if (re_at_stop && c == STOP_OFS) begin
                head = exp_q.pop_front();
                checks++;
                if (bus.data !== head) begin
                    errors++;
                    $display("FAIL head_at_push: data=%h expected %h", bus.data, head);
                end
            end
            if (chk_lat && c == STOP_OFS) begin
                checks++;
                if (bus.empty !== 1'b1) begin
                    errors++;
                    $display("FAIL empty_before_stop: empty=%b expected 1", bus.empty);
                end
            end
            if (chk_lat && c == STOP_OFS + 1) begin
                checks++;
                if (bus.empty !== 1'b0 || bus.data !== b) begin
                    errors++;
                    $display("FAIL first_byte_latency: empty=%b data=%h expected 0 %h",
                             bus.empty, bus.data, b);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.rx_serial = 1'b1;
        bus.RE        = 1'b0;
        bus.err_clr   = 1'b0;
        if (stop_lvl && exp_q.size() < DEPTH) begin
            exp_q.push_back(b);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        idle(4);
        checks++;
        if (bus.data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: data=%h expected 00", bus.data);
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_empty_full: empty=%b full=%b expected 1 0", bus.empty, bus.full);
        end
        checks++;
        if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ovr=%b ferr=%b expected 0 0", bus.overrun, bus.frame_err);
        end
        areset = 1'b0;
        idle(4);
    endtask

    task automatic test_single_byte();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_b = exp_q.pop_front();
        checks++;
        if (bus.data !== exp_b || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL single_data: data=%h empty=%b expected %h 0", bus.data, bus.empty, exp_b);
        end
        pulse_re();
        checks++;
        if (bus.empty !== 1'b1 || bus.data !== 8'h00) begin
            errors++;
            $display("FAIL single_after_pop: empty=%b data=%h expected 1 00", bus.empty, bus.data);
        end
        // A read strobe on an empty FIFO must be ignored.
        pulse_re();
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL re_when_empty: empty=%b full=%b expected 1 0", bus.empty, bus.full);
        end
    endtask

    task automatic test_glitch();
        bus.rx_serial = 1'b0;
        idle(5);
        bus.rx_serial = 1'b1;
        idle(40);
        checks++;
        if (bus.empty !== 1'b1 || bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL glitch: empty=%b ovr=%b ferr=%b expected 1 0 0",
                     bus.empty, bus.overrun, bus.frame_err);
        end
        // Receiver must still be in sync for a real frame afterwards.
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_b = exp_q.pop_front();
        checks++;
        if (bus.data !== exp_b) begin
            errors++;
            $display("FAIL after_glitch: data=%h expected %h", bus.data, exp_b);
        end
        pulse_re();
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(30);
        checks++;
        if (bus.frame_err !== 1'b1 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_set: ferr=%b empty=%b expected 1 1", bus.frame_err, bus.empty);
        end
        pulse_clr();
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clr: ferr=%b expected 0", bus.frame_err);
        end
        // Set and clear in the same cycle: set wins.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(30);
        checks++;
        if (bus.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear: ferr=%b expected 1", bus.frame_err);
        end
        pulse_clr();
        checks++;
        if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clr2: ferr=%b ovr=%b expected 0 0", bus.frame_err, bus.overrun);
        end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (bus.full !== 1'b1 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL full_after_8: full=%b ovr=%b expected 1 0", bus.full, bus.overrun);
        end
        send_frame(8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.overrun !== 1'b1 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL overrun_after_9: ovr=%b full=%b expected 1 1", bus.overrun, bus.full);
        end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.empty !== 1'b0 || bus.data !== exp_b) begin
                errors++;
                $display("FAIL overrun_drain: data=%h empty=%b expected %h 0", bus.data, bus.empty, exp_b);
            end
            pulse_re();
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.data !== 8'h00) begin
            errors++;
            $display("FAIL overrun_drained: empty=%b full=%b data=%h expected 1 0 00",
                     bus.empty, bus.full, bus.data);
        end
        pulse_clr();
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr: ovr=%b expected 0", bus.overrun);
        end
    endtask

    task automatic test_full_read_at_push();
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (bus.full !== 1'b1) begin
            errors++;
            $display("FAIL prefill_full: full=%b expected 1", bus.full);
        end
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.overrun !== 1'b0 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_full: ovr=%b full=%b expected 0 1", bus.overrun, bus.full);
        end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.empty !== 1'b0 || bus.data !== exp_b) begin
                errors++;
                $display("FAIL full_rd_drain: data=%h empty=%b expected %h 0", bus.data, bus.empty, exp_b);
            end
            pulse_re();
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL full_rd_empty: empty=%b expected 1", bus.empty);
        end
    endtask

    task automatic test_back_to_back_reset_mid_frame();
        // Partial 0xFF frame: start bit and a few data bits, then reset.
        bus.rx_serial = 1'b0;
        idle(CPB);
        bus.rx_serial = 1'b1;
        idle(3 * CPB);
        areset = 1'b1;
        exp_q.delete();
        idle(3);
        areset = 1'b0;
        idle(20);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.empty !== 1'b0 || bus.data !== exp_b) begin
                errors++;
                $display("FAIL post_reset_rx: data=%h empty=%b expected %h 0", bus.data, bus.empty, exp_b);
            end
            pulse_re();
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_state: empty=%b ovr=%b ferr=%b expected 1 0 0",
                     bus.empty, bus.overrun, bus.frame_err);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        areset        = 1'b1;
        bus.rx_serial = 1'b1;
        bus.RE        = 1'b0;
        bus.err_clr   = 1'b0;
        #1;
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_read_at_push();
        test_back_to_back_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
